accel_speed_classifier: RTL

Parametrised successor to the two-axis accelerometer speed block. It accepts 2- or 3-axis signed samples through a valid/ready handshake and applies a per-axis change tolerance. On an accepted change it computes the exact floor square root of the sum of squares with a bit-serial restoring algorithm, then quantises the magnitude into a speed level with downward hysteresis. It sits between the accelerometer sampling logic and the speed/display consumers.

---
 rtl/accel_speed_classifier.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/accel_speed_classifier.sv
// Sample change filter, bit-serial floor sqrt of x^2+y^2+z^2 and speed classifier with downward hysteresis.
// Accept-to-done latency W+2 clocks; in_ready is low while a computation runs and samples offered then are not taken.
module accel_speed_classifier #(
  parameter int W      = 12,
  parameter int TOL    = 75,
  parameter int LEVELS = 5,
  parameter int STEP   = 200,
  parameter int HYST   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              x_acc,
  input  logic [W-1:0]              y_acc,
  input  logic [W-1:0]              z_acc,
  input  logic                      axis3_en,
  input  logic                      force_accept,
  output logic [W-1:0]              x_mag,
  output logic [W-1:0]              y_mag,
  output logic [W-1:0]              z_mag,
  output logic                      x_neg,
  output logic                      y_neg,
  output logic                      z_neg,
  output logic [W-1:0]              magnitude,
  output logic [$clog2(LEVELS)-1:0] speed,
  output logic                      done,
  output logic                      busy
);
  localparam int SW = $clog2(LEVELS);
  localparam int CW = $clog2(W);
  localparam int RW = 2*W + 2;
  localparam logic signed [W:0] TOL_S = TOL[W:0];

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, CLASSIFY} state_t;

  state_t          state_q, state_d;
  logic            first_q, first_d;
  logic [W-1:0]    xl_q, xl_d, yl_q, yl_d, zl_q, zl_d;
  logic [W-1:0]    x_mag_q, x_mag_d, y_mag_q, y_mag_d, z_mag_q, z_mag_d;
  logic            x_neg_q, x_neg_d, y_neg_q, y_neg_d, z_neg_q, z_neg_d;
  logic            ax3_q, ax3_d;
  logic [2*W-1:0]  sum_q, sum_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [W-1:0]    root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [SW-1:0]   speed_q, speed_d;
  logic            done_q, done_d;

  logic [W-1:0]    z_eff;
  logic signed [W:0] dx, dy, dz;
  logic            changed;
  logic [RW+1:0]   rem_sh, trial;
  logic [SW-1:0]   raw;
  int              thr;

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    // -2^(W-1) maps onto its own bit pattern, which read unsigned is 2^(W-1)
    return v[W-1] ? ((~v) + W'(1)) : v;
  endfunction

  function automatic logic over_tol(input logic signed [W:0] d);
    return (d > TOL_S) || (d < -TOL_S);
  endfunction

  always_comb begin
    z_eff   = axis3_en ? z_acc : '0;
    dx      = $signed({x_acc[W-1], x_acc}) - $signed({xl_q[W-1], xl_q});
    dy      = $signed({y_acc[W-1], y_acc}) - $signed({yl_q[W-1], yl_q});
    dz      = $signed({z_eff[W-1], z_eff}) - $signed({zl_q[W-1], zl_q});
    changed = over_tol(dx) || over_tol(dy) || (axis3_en && over_tol(dz));

    rem_sh  = {rem_q, sum_q[2*W-1 -: 2]};
    trial   = {{(W+2){1'b0}}, root_q, 2'b01};

    raw = '0;
    for (int k = 1; k < LEVELS; k++) begin
      if (int'(root_q) >= k*STEP) raw = SW'(k);
    end
    thr = 0;
    for (int k = 1; k < LEVELS; k++) begin
      if (speed_q == SW'(k)) thr = k*STEP - HYST;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    xl_d = xl_q;  yl_d = yl_q;  zl_d = zl_q;
    x_mag_d = x_mag_q;  y_mag_d = y_mag_q;  z_mag_d = z_mag_q;
    x_neg_d = x_neg_q;  y_neg_d = y_neg_q;  z_neg_d = z_neg_q;
    ax3_d   = ax3_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    speed_d = speed_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && (force_accept || first_q || changed)) begin
          first_d = 1'b0;
          xl_d = x_acc;  yl_d = y_acc;  zl_d = z_eff;
          x_mag_d = abs_w(x_acc);  y_mag_d = abs_w(y_acc);  z_mag_d = abs_w(z_eff);
          x_neg_d = x_acc[W-1];    y_neg_d = y_acc[W-1];    z_neg_d = z_eff[W-1];
          ax3_d   = axis3_en;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        sum_d  = {{W{1'b0}}, x_mag_q} * {{W{1'b0}}, x_mag_q}
               + {{W{1'b0}}, y_mag_q} * {{W{1'b0}}, y_mag_q}
               + {{W{1'b0}}, z_mag_q} * {{W{1'b0}}, z_mag_q};
        rem_d  = '0;
        root_d = '0;
        cnt_d  = '0;
        state_d = ROOT;
      end
      ROOT: begin
        // Bring down the next two radicand bits, try subtracting 4*root+1
        if (rem_sh >= trial) begin
          rem_d  = RW'(rem_sh - trial);
          root_d = {root_q[W-2:0], 1'b1};
        end else begin
          rem_d  = RW'(rem_sh);
          root_d = {root_q[W-2:0], 1'b0};
        end
        sum_d = {sum_q[2*W-3:0], 2'b00};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = CLASSIFY;
      end
      CLASSIFY: begin
        mag_d = root_q;
        if (raw >= speed_q) speed_d = raw;
        else if (int'(root_q) < thr) speed_d = raw;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      xl_q <= '0;  yl_q <= '0;  zl_q <= '0;
      x_mag_q <= '0;  y_mag_q <= '0;  z_mag_q <= '0;
      x_neg_q <= 1'b0;  y_neg_q <= 1'b0;  z_neg_q <= 1'b0;
      ax3_q   <= 1'b0;
      sum_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      mag_q   <= '0;
      speed_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      xl_q <= xl_d;  yl_q <= yl_d;  zl_q <= zl_d;
      x_mag_q <= x_mag_d;  y_mag_q <= y_mag_d;  z_mag_q <= z_mag_d;
      x_neg_q <= x_neg_d;  y_neg_q <= y_neg_d;  z_neg_q <= z_neg_d;
      ax3_q   <= ax3_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      speed_q <= speed_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = ~in_ready;
  assign x_mag     = x_mag_q;
  assign y_mag     = y_mag_q;
  assign z_mag     = z_mag_q;
  assign x_neg     = x_neg_q;
  assign y_neg     = y_neg_q;
  assign z_neg     = z_neg_q;
  assign magnitude = mag_q;
  assign speed     = speed_q;
  assign done      = done_q;

endmodule
